// File: rtl/mul_div_unit.sv
// Purpose : iterative unsigned 32-bit multiply (shift-add) / divide (restoring) unit feeding the reg_file write port.
// Latency : START accepted at edge k; the 32 iterations run at edges k+1..k+32; WR is high in the cycle after edge k+32.
// Backpr. : START is ignored while BUSY=1; a new START may be accepted on the result-cycle edge (back-to-back).
//
// Ports:
//   CLK            clock, rising edge
//   CLR            synchronous active-low reset
//   START          request, sampled when BUSY=0
//   OP[1:0]        00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   A, B           operand 1 (multiplicand/dividend), operand 2 (multiplier/divisor)
//   DEST[4:0]      destination register address
//   BUSY           operation in progress
//   D, AD, WR      registered write port: result, address, one-cycle strobe
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       DEST,
  output logic             BUSY,
  output logic [WIDTH-1:0] D,
  output logic [4:0]       AD,
  output logic             WR
);

  localparam int CW = $clog2(ITER) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt, acc_it;
  // sh: operand consumed one bit per iteration (multiplier for MUL, dividend for DIV)
  // fix: operand used whole every iteration (multiplicand for MUL, divisor for DIV)
  logic [WIDTH-1:0]   sh, sh_nxt;
  logic [WIDTH-1:0]   fix, fix_nxt;
  logic [1:0]         op_q, op_nxt;
  logic [4:0]         dest_q, dest_nxt;
  logic               busy_nxt, wr_nxt;
  logic [WIDTH-1:0]   d_nxt;
  logic [4:0]         ad_nxt;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     r_sh;
  logic               ge;
  logic [WIDTH-1:0]   diff;

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      sh     <= '0;
      fix    <= '0;
      op_q   <= '0;
      dest_q <= '0;
      BUSY   <= 1'b0;
      WR     <= 1'b0;
      D      <= '0;
      AD     <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      acc    <= acc_nxt;
      sh     <= sh_nxt;
      fix    <= fix_nxt;
      op_q   <= op_nxt;
      dest_q <= dest_nxt;
      BUSY   <= busy_nxt;
      WR     <= wr_nxt;
      D      <= d_nxt;
      AD     <= ad_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    sh_nxt    = sh;
    fix_nxt   = fix;
    op_nxt    = op_q;
    dest_nxt  = dest_q;
    d_nxt     = D;
    ad_nxt    = AD;
    acc_it    = acc;

    // Multiply step: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right. After
    // ITER steps acc holds the full 2*WIDTH-bit product.
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (sh[0] ? {1'b0, fix} : '0);

    // Divide step: upper half is the partial remainder, lower half collects
    // quotient bits. The shifted remainder needs WIDTH+1 bits; when it is not
    // below the divisor the true difference always fits in WIDTH bits.
    // A zero divisor makes every step "fit", giving an all-ones quotient and
    // leaving the dividend in the remainder with no special case.
    r_sh = {acc[2*WIDTH-1:WIDTH], sh[WIDTH-1]};
    ge   = (r_sh >= {1'b0, fix});
    diff = r_sh[WIDTH-1:0] - fix;

    if (op_q[1]) begin
      acc_it = {(ge ? diff : r_sh[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    end else begin
      acc_it = {mul_sum, acc[WIDTH-1:1]};
    end

    case (state)
      IDLE, DONE: begin
        if (START) begin
          state_nxt = RUN;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          op_nxt    = OP;
          dest_nxt  = DEST;
          sh_nxt    = OP[1] ? A : B;
          fix_nxt   = OP[1] ? B : A;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        acc_nxt = acc_it;
        sh_nxt  = op_q[1] ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(ITER - 1)) begin
          state_nxt = DONE;
          // Low half: product low / quotient. High half: product high / remainder.
          d_nxt  = op_q[0] ? acc_it[2*WIDTH-1:WIDTH] : acc_it[WIDTH-1:0];
          ad_nxt = dest_q;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == RUN);
    wr_nxt   = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic        CLK;
  logic        CLR;
  logic        START;
  logic [1:0]  OP;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  DEST;
  logic        BUSY;
  logic [31:0] D;
  logic [4:0]  AD;
  logic        WR;

  int errors = 0;
  int checks = 0;

  mul_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .START (START),
    .OP    (OP),
    .A     (A),
    .B     (B),
    .DEST  (DEST),
    .BUSY  (BUSY),
    .D     (D),
    .AD    (AD),
    .WR    (WR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference: plain unsigned arithmetic on 64-bit values.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Issues one request (accepted at edge k) and observes 40 cycles after it.
  // Observation j is taken at the falling edge just before edge k+j.
  // junk_j > 0 drives a conflicting START for edge k+junk_j.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dest, input int junk_j,
                        output int busy_n, output int wr_j, output int wr_n,
                        output logic [31:0] d_obs, output logic [4:0] ad_obs);
    @(negedge CLK);
    START = 1'b1; OP = op; A = a; B = b; DEST = dest;
    @(posedge CLK);
    busy_n = 0; wr_j = 0; wr_n = 0; d_obs = '0; ad_obs = '0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge CLK);
      START = 1'b0;
      A = $urandom; B = $urandom; OP = 2'($urandom); DEST = 5'($urandom);
      if (BUSY) busy_n += (j <= 32) ? 1 : 100;
      if (WR) begin
        wr_n++;
        if (wr_j == 0) begin
          wr_j = j; d_obs = D; ad_obs = AD;
        end
      end
      if (j == junk_j) begin
        START = 1'b1; OP = ~op; DEST = ~dest; A = 32'd5; B = 32'd3;
      end
    end
  endtask

  task automatic test_reset();
    CLR = 1'b0; START = 1'b1; OP = 2'd0; A = 32'd3; B = 32'd4; DEST = 5'd7;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    checks++; if (WR !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b expected 0", WR); end
    checks++; if (D !== 32'd0) begin errors++; $display("FAIL reset_d: got %h expected 0", D); end
    checks++; if (AD !== 5'd0) begin errors++; $display("FAIL reset_ad: got %0d expected 0", AD); end
    CLR = 1'b1; START = 1'b0;
  endtask

  task automatic test_mul();
    int bn, wj, wn; logic [31:0] d; logic [4:0] ad;
    run_op(2'd0, 32'd7, 32'd6, 5'd3, 0, bn, wj, wn, d, ad);
    checks++; if (bn !== 32) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected 32", bn); end
    checks++; if (wj !== 33) begin errors++; $display("FAIL mul_wr_edge: got k+%0d expected k+33", wj); end
    checks++; if (wn !== 1) begin errors++; $display("FAIL mul_wr_count: got %0d expected 1", wn); end
    checks++; if (d !== 32'd42) begin errors++; $display("FAIL mul_d: got %0d expected 42", d); end
    checks++; if (ad !== 5'd3) begin errors++; $display("FAIL mul_ad: got %0d expected 3", ad); end
  endtask

  task automatic test_corners();
    logic [1:0]  t_op[8]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3};
    logic [31:0] t_a[8]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100,
                              32'h8000_0000, 32'h8000_0000, 32'h1234, 32'h1234};
    logic [31:0] t_b[8]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd1, 32'd1, 32'd0, 32'd0};
    logic [31:0] t_exp[8] = '{32'h1, 32'hFFFF_FFFE, 32'd14, 32'd2, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h1234};
    int bn, wj, wn; logic [31:0] d; logic [4:0] ad;
    for (int i = 0; i < 8; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 5'(i + 1), 0, bn, wj, wn, d, ad);
      checks++;
      if (d !== t_exp[i]) begin errors++; $display("FAIL corner%0d_d: got %h expected %h", i, d, t_exp[i]); end
      checks++;
      if (wj !== 33 || wn !== 1) begin
        errors++; $display("FAIL corner%0d_wr: got edge k+%0d count %0d expected k+33 count 1", i, wj, wn);
      end
    end
  endtask

  task automatic test_random();
    int bn, wj, wn; logic [31:0] d; logic [4:0] ad;
    logic [1:0] op; logic [31:0] a, b; logic [4:0] dest; logic [31:0] exp;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom); a = $urandom; dest = 5'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      exp = model(op, a, b);
      run_op(op, a, b, dest, 0, bn, wj, wn, d, ad);
      checks++;
      if (d !== exp) begin errors++; $display("FAIL rand%0d_d op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, d, exp); end
      checks++;
      if (ad !== dest) begin errors++; $display("FAIL rand%0d_ad: got %0d expected %0d", i, ad, dest); end
      checks++;
      if (wj !== 33 || wn !== 1 || bn !== 32) begin
        errors++; $display("FAIL rand%0d_timing: wr k+%0d count %0d busy %0d expected k+33 1 32", i, wj, wn, bn);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int bn, wj, wn; logic [31:0] d; logic [4:0] ad;
    run_op(2'd2, 32'd1000, 32'd33, 5'd9, 10, bn, wj, wn, d, ad);
    checks++; if (d !== model(2'd2, 32'd1000, 32'd33)) begin errors++; $display("FAIL ignore_d: got %0d expected 30", d); end
    checks++; if (ad !== 5'd9) begin errors++; $display("FAIL ignore_ad: got %0d expected 9", ad); end
    checks++; if (wn !== 1 || wj !== 33) begin errors++; $display("FAIL ignore_wr: got count %0d edge k+%0d expected 1 k+33", wn, wj); end
    checks++; if (bn !== 32) begin errors++; $display("FAIL ignore_busy: got %0d expected 32", bn); end
  endtask

  task automatic test_back_to_back();
    int wn = 0;
    int wj[2] = '{0, 0};
    logic [31:0] wd[2];
    logic [4:0]  wa[2];
    logic        busy34 = 1'b0;
    @(negedge CLK);
    START = 1'b1; OP = 2'd3; A = 32'd100; B = 32'd7; DEST = 5'd12;
    @(posedge CLK);
    for (int j = 1; j <= 80; j++) begin
      @(negedge CLK);
      START = 1'b0;
      if (j == 34) busy34 = BUSY;
      if (WR) begin
        if (wn < 2) begin wj[wn] = j; wd[wn] = D; wa[wn] = AD; end
        wn++;
      end
      if (j == 33) begin
        START = 1'b1; OP = 2'd1; A = 32'h0001_0000; B = 32'h0003_0000; DEST = 5'd0;
      end
    end
    checks++; if (wn !== 2) begin errors++; $display("FAIL b2b_wr_count: got %0d expected 2", wn); end
    checks++; if (wj[0] !== 33 || wj[1] !== 66) begin errors++; $display("FAIL b2b_wr_edges: got k+%0d k+%0d expected k+33 k+66", wj[0], wj[1]); end
    checks++; if (busy34 !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy34); end
    checks++; if (wd[0] !== 32'd2 || wa[0] !== 5'd12) begin errors++; $display("FAIL b2b_first: got %h@%0d expected 2@12", wd[0], wa[0]); end
    checks++; if (wd[1] !== 32'd3 || wa[1] !== 5'd0) begin errors++; $display("FAIL b2b_second: got %h@%0d expected 3@0", wd[1], wa[1]); end
  endtask

  task automatic test_reset_midop();
    int bn, wj, wn; logic [31:0] d; logic [4:0] ad;
    int stray = 0;
    @(negedge CLK);
    START = 1'b1; OP = 2'd0; A = 32'd11; B = 32'd13; DEST = 5'd21;
    @(posedge CLK);
    for (int j = 1; j <= 15; j++) begin
      @(negedge CLK);
      START = 1'b0;
      if (j == 15) CLR = 1'b0;
    end
    @(negedge CLK);
    CLR = 1'b1;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", BUSY); end
    checks++; if (D !== 32'd0 || AD !== 5'd0) begin errors++; $display("FAIL midrst_d_ad: got %h/%0d expected 0/0", D, AD); end
    for (int j = 0; j < 50; j++) begin
      if (WR) stray++;
      @(negedge CLK);
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL midrst_no_wr: got %0d pulses expected 0", stray); end
    run_op(2'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd30, 0, bn, wj, wn, d, ad);
    checks++; if (d !== model(2'd1, 32'hDEAD_BEEF, 32'h1234_5678)) begin errors++; $display("FAIL midrst_fresh_d: got %h", d); end
    checks++; if (wj !== 33 || wn !== 1 || ad !== 5'd30) begin errors++; $display("FAIL midrst_fresh_wr: edge k+%0d count %0d ad %0d expected k+33 1 30", wj, wn, ad); end
  endtask

  initial begin
    CLR = 1'b0; START = 1'b0; OP = 2'd0; A = '0; B = '0; DEST = '0;
    test_reset();
    test_mul();
    test_corners();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
